// File: rtl/fb_rect_fill.sv
// Filled-rectangle drawer: writes a solid colour index into a clipped rectangle
// of a linear framebuffer, one pixel per oe-enabled cycle, in raster order.
module fb_rect_fill #(
    parameter int unsigned FB_WIDTH  = 160,
    parameter int unsigned FB_HEIGHT = 120,
    parameter int unsigned CORDW     = 16,
    parameter int unsigned CIDXW     = 4,
    parameter int unsigned ADDRW     = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CORDW-1:0] x0,
    input  logic [CORDW-1:0] y0,
    input  logic [CORDW-1:0] x1,
    input  logic [CORDW-1:0] y1,
    input  logic [CIDXW-1:0] colr,
    input  logic             oe,
    output logic             busy,
    output logic             done,
    output logic             we,
    output logic [ADDRW-1:0] addr,
    output logic [CIDXW-1:0] data
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        DRAW,
        DONE
    } state_t;

    localparam logic [CORDW-1:0] XW    = CORDW'(FB_WIDTH);
    localparam logic [CORDW-1:0] YH    = CORDW'(FB_HEIGHT);
    localparam logic [CORDW-1:0] XLAST = CORDW'(FB_WIDTH - 1);
    localparam logic [CORDW-1:0] YLAST = CORDW'(FB_HEIGHT - 1);
    localparam logic [ADDRW-1:0] FBW_A = ADDRW'(FB_WIDTH);

    state_t           state_q, state_d;
    logic [CORDW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CORDW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [CORDW-1:0] x_q, x_d, y_q, y_d;
    logic [ADDRW-1:0] rowbase_q, rowbase_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [CIDXW-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CORDW-1:0] sx_min, sx_max, sy_min, sy_max;
    logic [CORDW-1:0] cx_max, cy_max;
    logic [ADDRW-1:0] init_rowbase, next_rowbase;

    // Corner sorting, clipping and row-base arithmetic shared by INIT and DRAW
    always_comb begin
        sx_min       = (x0_q < x1_q) ? x0_q : x1_q;
        sx_max       = (x0_q < x1_q) ? x1_q : x0_q;
        sy_min       = (y0_q < y1_q) ? y0_q : y1_q;
        sy_max       = (y0_q < y1_q) ? y1_q : y0_q;
        cx_max       = (sx_max > XLAST) ? XLAST : sx_max;
        cy_max       = (sy_max > YLAST) ? YLAST : sy_max;
        init_rowbase = ADDRW'(sy_min) * FBW_A;
        next_rowbase = rowbase_q + FBW_A;
    end

    // Next-state and datapath update for the fill sequencer
    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        xmin_d    = xmin_q;
        xmax_d    = xmax_q;
        ymax_d    = ymax_q;
        x_d       = x_q;
        y_d       = y_q;
        rowbase_d = rowbase_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    data_d  = colr;
                    busy_d  = 1'b1;
                    state_d = INIT;
                end
            end
            INIT: begin
                if (sx_min >= XW || sy_min >= YH) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    xmin_d    = sx_min;
                    xmax_d    = cx_max;
                    ymax_d    = cy_max;
                    x_d       = sx_min;
                    y_d       = sy_min;
                    rowbase_d = init_rowbase;
                    addr_d    = init_rowbase + ADDRW'(sx_min);
                    state_d   = DRAW;
                end
            end
            DRAW: begin
                if (oe) begin
                    if (x_q < xmax_q) begin
                        x_d    = x_q + CORDW'(1);
                        addr_d = addr_q + ADDRW'(1);
                    end else if (y_q < ymax_q) begin
                        x_d       = xmin_q;
                        y_d       = y_q + CORDW'(1);
                        rowbase_d = next_rowbase;
                        addr_d    = next_rowbase + ADDRW'(xmin_q);
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any fill in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymax_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            rowbase_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymax_q    <= ymax_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rowbase_q <= rowbase_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Write strobe follows oe directly so a stall takes effect in the same cycle
    always_comb begin
        we = (state_q == DRAW) && oe;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: a raster-order address model feeds an
// expected-write queue that a negedge monitor drains on every write.
module tb_fb_rect_fill;

    localparam int FBW = 160;
    localparam int FBH = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [3:0]  colr = '0;
    logic        oe = 1'b1;
    logic        busy, done, we;
    logic [14:0] addr;
    logic [3:0]  data;

    int checks = 0;
    int fails  = 0;
    int exp_q[$];
    int exp_data = 0;
    int writes_seen = 0;

    fb_rect_fill #(
        .FB_WIDTH (FBW),
        .FB_HEIGHT(FBH),
        .CORDW    (16),
        .CIDXW    (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x0   (x0),
        .y0   (y0),
        .x1   (x1),
        .y1   (y1),
        .colr (colr),
        .oe   (oe),
        .busy (busy),
        .done (done),
        .we   (we),
        .addr (addr),
        .data (data)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every write must match the head of the expected raster sequence
    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", int'(addr), -1);
                end else begin
                    chk("write_addr", int'(addr), exp_q[0]);
                    chk("write_data", int'(data), exp_data);
                    void'(exp_q.pop_front());
                end
            end
            if (done) chk("pending_writes_at_done", exp_q.size(), 0);
        end
    end

    // Reference: sort, clip, then list pixels row by row
    task automatic build(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
        int xmn, xmx, ymn, ymx;
        xmn = (ax0 < ax1) ? ax0 : ax1;
        xmx = (ax0 < ax1) ? ax1 : ax0;
        ymn = (ay0 < ay1) ? ay0 : ay1;
        ymx = (ay0 < ay1) ? ay1 : ay0;
        if (xmx > FBW - 1) xmx = FBW - 1;
        if (ymx > FBH - 1) ymx = FBH - 1;
        exp_q.delete();
        exp_data = c;
        if (xmn < FBW && ymn < FBH)
            for (int y = ymn; y <= ymx; y++)
                for (int x = xmn; x <= xmx; x++)
                    exp_q.push_back(y * FBW + x);
    endtask

    // Issue one fill; k counts cycles after the start cycle (k=0)
    task automatic drive(input int ax0, input int ay0, input int ax1, input int ay1, input int c,
                         input bit rnd, input int exp_writes, input int exp_first,
                         input int exp_done, input int repulse_k, input int rst_k);
        int first_k, last_k, done_k, wr;
        bit aborted;
        first_k = -1; last_k = -1; done_k = -1; wr = 0; aborted = 1'b0;
        @(posedge clk); #1;
        x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1); colr = 4'(c);
        start = 1'b1; oe = 1'b1;
        #2 chk("busy_idle_at_start", int'(busy), 0);
        for (int k = 1; k <= 500; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == repulse_k) begin
                x0 = 16'd20; y0 = 16'd20; x1 = 16'd22; y1 = 16'd22; colr = 4'd11;
                start = 1'b1;
            end
            oe = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                chk("rst_we", int'(we), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            #2;
            chk("busy_during_fill", int'(busy), 1);
            if (we) begin
                wr++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(posedge clk); #1 rst = 1'b0;
            return;
        end
        if (done_k < 0) chk("done_timeout", 0, 1);
        chk("write_count", wr, exp_writes);
        chk("model_drained", exp_q.size(), 0);
        if (exp_first >= 0) chk("first_write_cycle", first_k, exp_first);
        if (exp_done >= 0) chk("done_cycle", done_k, exp_done);
        if (rnd && wr > 0) chk("done_after_last_write", done_k, last_k + 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #3;
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
            chk("idle_we", int'(we), 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_we", int'(we), 0);
        chk("reset_addr", int'(addr), 0);
        chk("reset_data", int'(data), 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: basic 4x2 box
        build(2, 1, 5, 2, 7);
        chk("model_t1_first", exp_q[0], 162);
        chk("model_t1_fourth", exp_q[3], 165);
        chk("model_t1_fifth", exp_q[4], 322);
        chk("model_t1_last", exp_q[7], 325);
        drive(2, 1, 5, 2, 7, 1'b0, 8, 2, 10, -1, -1);

        // 2: swapped corners
        build(5, 2, 2, 1, 7);
        drive(5, 2, 2, 1, 7, 1'b0, 8, 2, 10, -1, -1);

        // 3: clipped at bottom-right corner
        build(158, 118, 200, 300, 9);
        chk("model_t3_first", exp_q[0], 19038);
        chk("model_t3_second", exp_q[1], 19039);
        chk("model_t3_third", exp_q[2], 19198);
        chk("model_t3_last", exp_q[3], 19199);
        drive(158, 118, 200, 300, 9, 1'b0, 4, 2, 6, -1, -1);

        // 4: fully off-screen
        build(200, 5, 210, 9, 1);
        chk("model_t4_empty", exp_q.size(), 0);
        drive(200, 5, 210, 9, 1, 1'b0, 0, -1, 2, -1, -1);

        // single pixel
        build(10, 10, 10, 10, 5);
        chk("model_single", exp_q[0], 1610);
        drive(10, 10, 10, 10, 5, 1'b0, 1, 2, 3, -1, -1);

        // 5: oe toggling
        build(2, 1, 5, 2, 7);
        drive(2, 1, 5, 2, 7, 1'b1, 8, -1, -1, -1, -1);

        // 6a: start re-pulsed while drawing is ignored
        build(0, 0, 3, 0, 2);
        drive(0, 0, 3, 0, 2, 1'b0, 4, 2, 6, 3, -1);

        // 6b: reset mid-DRAW, then a fresh fill
        build(2, 1, 5, 2, 7);
        drive(2, 1, 5, 2, 7, 1'b0, 8, 2, 10, -1, 5);
        build(2, 1, 5, 2, 12);
        drive(2, 1, 5, 2, 12, 1'b0, 8, 2, 10, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
